// File: rtl/cia_arb_pkg.sv
// Shared types and constants for the CIA bus arbiter.
package cia_arb_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CPU_CYC   = 2'd1,
    HOST_CYC  = 2'd2,
    HOST_DONE = 2'd3
  } arb_state_t;

  // Interrupt control register: reading it clears pending CIA interrupts.
  localparam logic [3:0] ICR_RS_DEFAULT = 4'hD;

endpackage

// File: rtl/cia_bus_arbiter.sv
// Shares one CIA between the native CPU and a host port. The CPU always wins at
// a Phi2 rising edge; the host gets the slot only when the CPU leaves it unused.
// All CIA-side signals are registered and change only at cycle boundaries.
module cia_bus_arbiter
  import cia_arb_pkg::*;
#(
  parameter int         HOST_RD_PROTECT = 1,
  parameter logic [3:0] ICR_RS          = ICR_RS_DEFAULT
) (
  input  logic       clk,
  input  logic       res,
  input  logic       phi2_p,
  input  logic       phi2_n,
  input  logic       cpu_cs_n,
  input  logic       cpu_rw,
  input  logic [3:0] cpu_rs,
  input  logic [7:0] cpu_db_in,
  output logic [7:0] cpu_db_out,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [3:0] host_rs,
  input  logic [7:0] host_wdata,
  output logic       host_ack,
  output logic       host_err,
  output logic [7:0] host_rdata,
  output logic       cia_cs_n,
  output logic       cia_rw,
  output logic [3:0] cia_rs,
  output logic [7:0] cia_db_in,
  input  logic [7:0] cia_db_out
);

  arb_state_t state_q, state_d;
  logic       seen_n_q, seen_n_d;
  logic       blocked_q, blocked_d;
  logic       err_q, err_d;
  logic       cs_n_d, rw_d;
  logic [3:0] rs_d;
  logic [7:0] db_d, rdata_d;

  arb_state_t g_state;
  logic       g_cs_n, g_rw, g_blocked;
  logic [3:0] g_rs;
  logic [7:0] g_db;

  logic       host_rd_blocked;
  logic       load_grant, go_idle;

  // A host read of the ICR would silently clear CIA interrupts owned by the CPU.
  assign host_rd_blocked = (HOST_RD_PROTECT != 0) && !host_we && (host_rs == ICR_RS);

  // CPU read data comes straight from the CIA, no extra latency.
  assign cpu_db_out = cia_db_out;

  // Ack is the HOST_DONE state itself; err only qualifies that single clk.
  assign host_ack = (state_q == HOST_DONE);
  assign host_err = host_ack & err_q;

  // Who would own the bus if a Phi2 rising edge were seen right now.
  always_comb begin
    g_state   = IDLE;
    g_cs_n    = 1'b1;
    g_rw      = 1'b1;
    g_rs      = 4'h0;
    g_db      = 8'h00;
    g_blocked = 1'b0;
    if (!cpu_cs_n) begin
      g_state = CPU_CYC;
      g_cs_n  = 1'b0;
      g_rw    = cpu_rw;
      g_rs    = cpu_rs;
      g_db    = cpu_db_in;
    end else if (host_req) begin
      g_state   = HOST_CYC;
      g_blocked = host_rd_blocked;
      if (!host_rd_blocked) begin
        g_cs_n = 1'b0;
        g_rw   = !host_we;
        g_rs   = host_rs;
        g_db   = host_wdata;
      end
    end
  end

  // Next-state and next-register decode; phi2_p always outranks phi2_n.
  always_comb begin
    state_d    = state_q;
    seen_n_d   = seen_n_q;
    blocked_d  = blocked_q;
    err_d      = err_q;
    cs_n_d     = cia_cs_n;
    rw_d       = cia_rw;
    rs_d       = cia_rs;
    db_d       = cia_db_in;
    rdata_d    = host_rdata;
    load_grant = 1'b0;
    go_idle    = 1'b0;

    case (state_q)
      IDLE: begin
        if (phi2_p) load_grant = 1'b1;
      end
      CPU_CYC: begin
        if (phi2_p)        load_grant = 1'b1;
        else if (seen_n_q) go_idle = 1'b1;
        else if (phi2_n)   seen_n_d = 1'b1;
      end
      HOST_CYC: begin
        if (seen_n_q) begin
          state_d  = HOST_DONE;
          seen_n_d = 1'b0;
          err_d    = blocked_q;
          cs_n_d   = 1'b1;
          rw_d     = 1'b1;
          rs_d     = 4'h0;
          db_d     = 8'h00;
          if (blocked_q)   rdata_d = 8'h00;
          else if (cia_rw) rdata_d = cia_db_out;
        end else if (phi2_n && !phi2_p) begin
          seen_n_d = 1'b1;
        end
      end
      HOST_DONE: begin
        // host_req on this clk still belongs to the request being acked,
        // so only the CPU may claim a coincident Phi2 edge.
        if (phi2_p && !cpu_cs_n) load_grant = 1'b1;
        else                     go_idle = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase

    if (load_grant) begin
      state_d   = g_state;
      seen_n_d  = 1'b0;
      blocked_d = g_blocked;
      cs_n_d    = g_cs_n;
      rw_d      = g_rw;
      rs_d      = g_rs;
      db_d      = g_db;
    end else if (go_idle) begin
      state_d   = IDLE;
      seen_n_d  = 1'b0;
      blocked_d = 1'b0;
      cs_n_d    = 1'b1;
      rw_d      = 1'b1;
      rs_d      = 4'h0;
      db_d      = 8'h00;
    end
  end

  // State and registered outputs; reset abandons any cycle in flight.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= IDLE;
      seen_n_q   <= 1'b0;
      blocked_q  <= 1'b0;
      err_q      <= 1'b0;
      cia_cs_n   <= 1'b1;
      cia_rw     <= 1'b1;
      cia_rs     <= 4'h0;
      cia_db_in  <= 8'h00;
      host_rdata <= 8'h00;
    end else begin
      state_q    <= state_d;
      seen_n_q   <= seen_n_d;
      blocked_q  <= blocked_d;
      err_q      <= err_d;
      cia_cs_n   <= cs_n_d;
      cia_rw     <= rw_d;
      cia_rs     <= rs_d;
      cia_db_in  <= db_d;
      host_rdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_cia_bus_arbiter.sv
// Directed bench for cia_bus_arbiter: each Phi2 cycle is 8 clks with phi2_p
// sampled at slot 0 and phi2_n at slot 3.
module tb_cia_bus_arbiter;

  logic       clk = 1'b0;
  logic       res;
  logic       phi2_p, phi2_n;
  logic       cpu_cs_n, cpu_rw;
  logic [3:0] cpu_rs;
  logic [7:0] cpu_db_in, cpu_db_out;
  logic       host_req, host_we;
  logic [3:0] host_rs;
  logic [7:0] host_wdata;
  logic       host_ack, host_err;
  logic [7:0] host_rdata;
  logic       cia_cs_n, cia_rw;
  logic [3:0] cia_rs;
  logic [7:0] cia_db_in, cia_db_out;

  int checkCount = 0;
  int passCount  = 0;

  logic       pCsN, pRw, nCsN, endCsN, errAtAck, errOutsideAck;
  logic [3:0] pRs;
  logic [7:0] pDb, nDb;
  int         ackCount, ackSlot, csLowCount, totalAcks;

  cia_bus_arbiter dut (
    .clk(clk), .res(res), .phi2_p(phi2_p), .phi2_n(phi2_n),
    .cpu_cs_n(cpu_cs_n), .cpu_rw(cpu_rw), .cpu_rs(cpu_rs),
    .cpu_db_in(cpu_db_in), .cpu_db_out(cpu_db_out),
    .host_req(host_req), .host_we(host_we), .host_rs(host_rs),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_err(host_err),
    .host_rdata(host_rdata), .cia_cs_n(cia_cs_n), .cia_rw(cia_rw),
    .cia_rs(cia_rs), .cia_db_in(cia_db_in), .cia_db_out(cia_db_out)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // One Phi2 cycle. reqMode 0 keeps host_req, 1 drops it when ack is seen,
  // 2 drops it right after the grant edge. resetSlot pulses res in that slot.
  task automatic applyStimulus(input int reqMode, input int resetSlot);
    ackCount = 0; ackSlot = -1; errAtAck = 1'b0; errOutsideAck = 1'b0; csLowCount = 0;
    for (int i = 0; i < 8; i++) begin
      phi2_p = (i == 0);
      phi2_n = (i == 3);
      if (i == resetSlot) res = 1'b1;
      @(posedge clk); #1;
      res = 1'b0; phi2_p = 1'b0; phi2_n = 1'b0;
      if (!cia_cs_n) csLowCount++;
      if (host_ack) begin
        ackCount++; ackSlot = i; errAtAck = host_err;
        if (reqMode == 1) host_req = 1'b0;
      end else if (host_err) begin
        errOutsideAck = 1'b1;
      end
      if (i == 0) begin
        pCsN = cia_cs_n; pRw = cia_rw; pRs = cia_rs; pDb = cia_db_in;
        if (reqMode == 2) host_req = 1'b0;
      end
      if (i == 3) begin nCsN = cia_cs_n; nDb = cia_db_in; end
      if (i == 7) endCsN = cia_cs_n;
    end
  endtask

  initial begin
    res = 1'b1; phi2_p = 1'b0; phi2_n = 1'b0;
    cpu_cs_n = 1'b1; cpu_rw = 1'b1; cpu_rs = 4'h0; cpu_db_in = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_rs = 4'h0; host_wdata = 8'h00;
    cia_db_out = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cs_n", cia_cs_n, 1'b1);
    checkOutput("rst_rw", cia_rw, 1'b1);
    checkOutput("rst_rs", cia_rs, 4'h0);
    checkOutput("rst_db", cia_db_in, 8'h00);
    checkOutput("rst_ack", host_ack, 1'b0);
    checkOutput("rst_err", host_err, 1'b0);
    checkOutput("rst_rdata", host_rdata, 8'h00);
    res = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Host write, CPU idle.
    host_req = 1'b1; host_we = 1'b1; host_rs = 4'h2; host_wdata = 8'hFF;
    applyStimulus(1, -1);
    checkOutput("wr_p_cs_n", pCsN, 1'b0);
    checkOutput("wr_p_rw", pRw, 1'b0);
    checkOutput("wr_p_rs", pRs, 4'h2);
    checkOutput("wr_p_db", pDb, 8'hFF);
    checkOutput("wr_n_cs_n", nCsN, 1'b0);
    checkOutput("wr_n_db", nDb, 8'hFF);
    checkOutput("wr_ack_cnt", ackCount, 1);
    checkOutput("wr_ack_slot", ackSlot, 4);
    checkOutput("wr_err", errAtAck, 1'b0);
    checkOutput("wr_cs_low_cnt", csLowCount, 4);
    checkOutput("wr_end_cs_n", endCsN, 1'b1);

    // Host read of a normal register.
    cia_db_out = 8'h5A;
    host_req = 1'b1; host_we = 1'b0; host_rs = 4'h4;
    applyStimulus(1, -1);
    checkOutput("rd_p_rw", pRw, 1'b1);
    checkOutput("rd_rdata", host_rdata, 8'h5A);
    checkOutput("rd_ack_cnt", ackCount, 1);
    checkOutput("rd_err", errAtAck, 1'b0);

    // CPU and host collide: CPU first, host next cycle.
    cpu_cs_n = 1'b0; cpu_rw = 1'b1; cpu_rs = 4'h3; cpu_db_in = 8'h11;
    host_req = 1'b1; host_we = 1'b1; host_rs = 4'h7; host_wdata = 8'h33;
    applyStimulus(1, -1);
    checkOutput("col_cpu_rs", pRs, 4'h3);
    checkOutput("col_cpu_rw", pRw, 1'b1);
    checkOutput("col_cpu_no_ack", ackCount, 0);
    cia_db_out = 8'hC3;
    #1;
    checkOutput("cpu_db_out", cpu_db_out, 8'hC3);
    cpu_cs_n = 1'b1;
    applyStimulus(1, -1);
    checkOutput("col_host_rs", pRs, 4'h7);
    checkOutput("col_host_db", pDb, 8'h33);
    checkOutput("col_host_ack", ackCount, 1);

    // Protected ICR read: no CIA access, error with ack.
    host_req = 1'b1; host_we = 1'b0; host_rs = 4'hD;
    applyStimulus(1, -1);
    checkOutput("icr_rd_cs_low", csLowCount, 0);
    checkOutput("icr_rd_ack", ackCount, 1);
    checkOutput("icr_rd_slot", ackSlot, 4);
    checkOutput("icr_rd_err", errAtAck, 1'b1);
    checkOutput("icr_rd_err_only_ack", errOutsideAck, 1'b0);
    checkOutput("icr_rd_rdata", host_rdata, 8'h00);

    // ICR write is allowed through.
    host_req = 1'b1; host_we = 1'b1; host_rs = 4'hD; host_wdata = 8'h81;
    applyStimulus(1, -1);
    checkOutput("icr_wr_cs_low", csLowCount, 4);
    checkOutput("icr_wr_rs", pRs, 4'hD);
    checkOutput("icr_wr_err", errAtAck, 1'b0);

    // Request withdrawn before any phi2_p.
    host_we = 1'b0; host_rs = 4'h4; host_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    host_req = 1'b0;
    applyStimulus(0, -1);
    checkOutput("wd_cs_low", csLowCount, 0);
    checkOutput("wd_ack", ackCount, 0);

    // Refresh rdata, then reset in the middle of a host read.
    cia_db_out = 8'h5A; host_req = 1'b1;
    applyStimulus(1, -1);
    checkOutput("pre_rst_rdata", host_rdata, 8'h5A);
    cia_db_out = 8'h77; host_req = 1'b1;
    applyStimulus(2, 2);
    checkOutput("mid_rst_cs_low", csLowCount, 2);
    checkOutput("mid_rst_ack", ackCount, 0);
    checkOutput("mid_rst_end_cs_n", endCsN, 1'b1);
    checkOutput("mid_rst_rdata", host_rdata, 8'h00);

    // Drop host_req right after grant: cycle still completes.
    host_req = 1'b1; host_we = 1'b1; host_rs = 4'h6; host_wdata = 8'h42;
    applyStimulus(2, -1);
    checkOutput("drop_after_grant_ack", ackCount, 1);

    // Request held through ack is served again next cycle.
    host_req = 1'b1; host_rs = 4'h5; host_wdata = 8'h24;
    applyStimulus(0, -1);
    checkOutput("hold_ack1", ackCount, 1);
    applyStimulus(0, -1);
    checkOutput("hold_ack2", ackCount, 1);
    checkOutput("hold_rs2", pRs, 4'h5);
    host_req = 1'b0;
    applyStimulus(0, -1);
    checkOutput("hold_released", ackCount, 0);

    // CPU busy for 10 cycles: host waits, then is acked.
    cpu_cs_n = 1'b0; cpu_rw = 1'b0; cpu_rs = 4'h1; cpu_db_in = 8'h99;
    host_req = 1'b1; host_we = 1'b1; host_rs = 4'h8; host_wdata = 8'hA5;
    totalAcks = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1, -1);
      totalAcks += ackCount;
    end
    checkOutput("busy_no_ack", totalAcks, 0);
    checkOutput("busy_cpu_rs", pRs, 4'h1);
    cpu_cs_n = 1'b1;
    applyStimulus(1, -1);
    checkOutput("busy_host_ack", ackCount, 1);
    checkOutput("busy_host_rs", pRs, 4'h8);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/cia_bus_arbiter.md
CIA_BUS_ARBITER -- requirements
Module: cia_bus_arbiter

Interface
REQ-001 SHALL have parameter HOST_RD_PROTECT, default 1, meaning: when 1, block host reads of the ICR (rs 4'hD).
REQ-002 SHALL have parameter ICR_RS, default 4'hD, meaning: register select treated as read-side-effect ICR.
REQ-003 clk  in  1  system clock; one clock for the whole block.
REQ-004 res  in  1  reset; asynchronous, active-high.
REQ-005 phi2_p  in  1  one-clk pulse at Phi2 positive edge.
REQ-006 phi2_n  in  1  one-clk pulse at Phi2 negative edge.
REQ-007 cpu_cs_n, cpu_rw  in  1 each  CPU chip select (active-low) and read/write (1 = read); stable when phi2_p is sampled.
REQ-008 cpu_rs  in  4  CPU register select.
REQ-009 cpu_db_in  in  8  CPU write data.
REQ-010 cpu_db_out  out  8  read data returned to CPU.
REQ-011 host_req, host_we  in  1 each  host request level and write enable.
REQ-012 host_rs  in  4  host register select.
REQ-013 host_wdata  in  8  host write data.
REQ-014 host_ack, host_err  out  1 each  completion pulse and error flag.
REQ-015 host_rdata  out  8  host read data.
REQ-016 cia_cs_n, cia_rw  out  1 each  to the CIA.
REQ-017 cia_rs  out  4  to the CIA.
REQ-018 cia_db_in  out  8  write data to the CIA.
REQ-019 cia_db_out  in  8  read data from the CIA; valid the clk after phi2_n.

Function
REQ-020 SHALL use FSM states IDLE, CPU_CYC, HOST_CYC, HOST_DONE; grant decided only on a clk with phi2_p=1.
REQ-021 At phi2_p: cpu_cs_n=0 -> CPU_CYC; else host_req=1 -> HOST_CYC; else IDLE. CPU has fixed priority.
REQ-022 cia_* outputs SHALL be registered, load on the phi2_p clk, and remain stable through the phi2_n clk inclusive.
REQ-023 In IDLE, cia_cs_n=1, cia_rw=1, cia_rs=0, cia_db_in=0.
REQ-024 cpu_db_out SHALL equal cia_db_out combinationally.
REQ-025 HOST_CYC: at the clk after phi2_n, capture cia_db_out into host_rdata (reads only) and go to HOST_DONE.
REQ-026 HOST_DONE SHALL last exactly one clk with host_ack=1, then go to IDLE; host_ack=0 in every other state.
REQ-027 A host_req still high on the clk after host_ack SHALL be treated as a new request.
REQ-028 Deasserting host_req before it is granted SHALL withdraw the request with no CIA access and no ack.
REQ-029 Deasserting host_req after grant SHALL NOT abort the cycle; host_ack SHALL still pulse.
REQ-030 With HOST_RD_PROTECT=1, a host read of ICR_RS SHALL NOT assert cia_cs_n, SHALL return host_rdata=8'h00, and SHALL raise host_err with host_ack in the same Phi2 cycle slot. Host writes to ICR_RS are allowed.
REQ-031 host_err is valid only while host_ack=1 and is 0 otherwise.
REQ-032 phi2_p and phi2_n on the same clk is illegal; the FSM SHALL give phi2_p priority.
REQ-033 A pending host request SHALL wait indefinitely while the CPU accesses the CIA each cycle; no preemption.

Reset
REQ-034 res=1 SHALL force IDLE immediately: cia_cs_n=1, cia_rw=1, cia_rs=0, cia_db_in=0, host_ack=0, host_err=0, host_rdata=0.
REQ-035 A cycle in flight at reset SHALL be dropped without an ack.

Structure
REQ-036 Package cia_arb_pkg SHALL hold the FSM state enum and the default ICR_RS constant.
REQ-037 Single module; no sub-module. The output mux and FSM live inline.

Verification
REQ-038 Host write, rs=4'h2, data 8'hFF, CPU idle -> cia_cs_n=0, cia_rw=0, cia_db_in=8'hFF from phi2_p+1 through phi2_n; host_ack at phi2_n+2.
REQ-039 Host read, rs=4'h4, cia_db_out=8'h5A -> host_rdata=8'h5A, host_ack=1, host_err=0.
REQ-040 CPU cs_n=0 and host_req=1 at the same phi2_p -> CPU granted; host served at the next phi2_p with cpu_cs_n=1.
REQ-041 Host read, rs=4'hD, HOST_RD_PROTECT=1 -> cia_cs_n stays 1; host_ack=1, host_err=1, host_rdata=8'h00.
REQ-042 host_req dropped before phi2_p -> no CIA access, no ack. res pulsed mid HOST_CYC -> IDLE, no ack.
REQ-043 CPU busy for 10 consecutive Phi2 cycles -> host waits; acked in the first cycle with cpu_cs_n=1.
